// File: rtl/zr_soc_pkg.sv
// Shared encodings for the mini SoC: RV32I opcode/funct fields, ALU operation set,
// default MMIO addresses and the ALU evaluation helper.
package zr_soc_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_LW   = 3'b010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    localparam logic [31:0] DEF_RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] DEF_FLAG_ADDR   = 32'h0000_1000;
    localparam logic [31:0] DEF_RESULT_ADDR = 32'h0000_1004;
    localparam logic [31:0] DEF_RAM_BASE    = 32'h0000_2000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    // alt selects SUB/SRA; the caller only raises it where funct7[5] is meaningful.
    function automatic alu_op_e alu_op_from(logic [2:0] funct3, logic alt);
        alu_op_e op;
        case (funct3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] alu_eval(alu_op_e op, logic [31:0] a, logic [31:0] b);
        logic [31:0] y;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << b[4:0];
            ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: y = {31'b0, a < b};
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> b[4:0];
            ALU_SRA:  y = $signed(a) >>> b[4:0];
            ALU_OR:   y = a | b;
            default:  y = a & b;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/zr_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port,
// x0 hardwired to zero, plus a debug tap on x10 (a0).
module zr_regfile (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_raddr_a,
    input  logic [4:0]  i_raddr_b,
    output logic [31:0] o_rdata_a,
    output logic [31:0] o_rdata_b,
    output logic [31:0] o_x10
);

    logic [31:0] r_regs [32];

    // NOTE: state is written with <= so every register samples pre-edge values, as hardware does.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = (i_raddr_a == 5'd0) ? '0 : r_regs[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == 5'd0) ? '0 : r_regs[i_raddr_b];
    assign o_x10     = r_regs[10];

endmodule

// File: rtl/zeroriscy_mini_soc.sv
// Single-cycle RV32I-subset SoC: ROM fetch, decode/execute, data RAM and two MMIO
// registers all commit on one rising edge per instruction; any illegal event halts the core.
module zeroriscy_mini_soc
    import zr_soc_pkg::*;
#(
    parameter int unsigned ROM_WORDS   = 256,
    parameter int unsigned RAM_WORDS   = 256,
    parameter string       ROM_INIT    = "prog.hex",
    parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
    parameter logic [31:0] FLAG_ADDR   = DEF_FLAG_ADDR,
    parameter logic [31:0] RESULT_ADDR = DEF_RESULT_ADDR,
    parameter logic [31:0] RAM_BASE    = DEF_RAM_BASE
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_enable_i,
    output logic        signal,
    output logic [31:0] result,
    output logic [31:0] mem_flag,
    output logic [31:0] mem_result,
    output logic [31:0] instr_addr
);

    localparam int unsigned ROM_AW    = $clog2(ROM_WORDS);
    localparam int unsigned RAM_AW    = $clog2(RAM_WORDS);
    localparam logic [31:0] ROM_BYTES = 32'(ROM_WORDS * 4);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    logic [31:0] r_rom [ROM_WORDS];
    logic [31:0] r_ram [RAM_WORDS];
    logic [31:0] r_pc;
    logic [31:0] r_mem_flag;
    logic [31:0] r_mem_result;
    logic        r_halted;

    logic        w_fetch_ok;
    logic [31:0] w_instr;
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

    assign w_fetch_ok = (r_pc[1:0] == 2'b00) && (r_pc < ROM_BYTES);
    // Out-of-range or misaligned PCs fetch the all-zero word, which decodes as illegal.
    assign w_instr  = w_fetch_ok ? r_rom[r_pc[2 +: ROM_AW]] : '0;
    assign w_opcode = w_instr[6:0];
    assign w_rd     = w_instr[11:7];
    assign w_funct3 = w_instr[14:12];
    assign w_rs1    = w_instr[19:15];
    assign w_rs2    = w_instr[24:20];
    assign w_funct7 = w_instr[31:25];
    assign w_imm_i  = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s  = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_imm_b  = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_imm_u  = {w_instr[31:12], 12'b0};
    assign w_imm_j  = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

    logic [31:0] w_rs1_val, w_rs2_val, w_x10, w_rf_wdata;
    logic        w_rf_we, w_rf_we_dec;

    zr_regfile u_regfile (
        .i_clk     (clk_i),
        .i_rst     (rst_ni),
        .i_we      (w_rf_we),
        .i_waddr   (w_rd),
        .i_wdata   (w_rf_wdata),
        .i_raddr_a (w_rs1),
        .i_raddr_b (w_rs2),
        .o_rdata_a (w_rs1_val),
        .o_rdata_b (w_rs2_val),
        .o_x10     (w_x10)
    );

    logic        w_alu_alt;
    alu_op_e     w_alu_op;
    logic [31:0] w_alu_b, w_alu_y;

    assign w_alu_alt = w_funct7[5] && ((w_opcode == OPC_OP) || (w_funct3 == F3_SR));
    assign w_alu_op  = alu_op_from(w_funct3, w_alu_alt);
    assign w_alu_b   = (w_opcode == OPC_OP) ? w_rs2_val : w_imm_i;
    assign w_alu_y   = alu_eval(w_alu_op, w_rs1_val, w_alu_b);

    logic w_taken;
    always_comb begin
        w_taken = 1'b0;
        case (w_funct3)
            F3_BEQ:  w_taken = (w_rs1_val == w_rs2_val);
            F3_BNE:  w_taken = (w_rs1_val != w_rs2_val);
            F3_BLT:  w_taken = ($signed(w_rs1_val) < $signed(w_rs2_val));
            F3_BGE:  w_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
            F3_BLTU: w_taken = (w_rs1_val < w_rs2_val);
            F3_BGEU: w_taken = (w_rs1_val >= w_rs2_val);
            default: w_taken = 1'b0;
        endcase
    end

    logic [31:0]       w_mem_addr, w_ram_off, w_load_data;
    logic              w_ram_hit, w_flag_hit, w_result_hit;
    logic [RAM_AW-1:0] w_ram_idx;

    assign w_mem_addr   = w_rs1_val + ((w_opcode == OPC_STORE) ? w_imm_s : w_imm_i);
    assign w_ram_off    = w_mem_addr - RAM_BASE;
    assign w_ram_hit    = (w_ram_off < RAM_BYTES);
    assign w_ram_idx    = w_ram_off[2 +: RAM_AW];
    assign w_flag_hit   = (w_mem_addr == FLAG_ADDR);
    assign w_result_hit = (w_mem_addr == RESULT_ADDR);

    always_comb begin
        w_load_data = '0;
        if (w_flag_hit)        w_load_data = r_mem_flag;
        else if (w_result_hit) w_load_data = r_mem_result;
        else if (w_ram_hit)    w_load_data = r_ram[w_ram_idx];
    end

    logic [31:0] w_pc_plus4, w_pc_next;
    logic        w_legal, w_ebreak, w_store_dec;

    assign w_pc_plus4 = r_pc + 32'd4;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_legal     = 1'b0;
        w_ebreak    = 1'b0;
        w_rf_we_dec = 1'b0;
        w_rf_wdata  = w_alu_y;
        w_store_dec = 1'b0;
        w_pc_next   = w_pc_plus4;
        case (w_opcode)
            OPC_LUI: begin
                w_legal = 1'b1; w_rf_we_dec = 1'b1; w_rf_wdata = w_imm_u;
            end
            OPC_AUIPC: begin
                w_legal = 1'b1; w_rf_we_dec = 1'b1; w_rf_wdata = r_pc + w_imm_u;
            end
            OPC_JAL: begin
                w_legal = 1'b1; w_rf_we_dec = 1'b1; w_rf_wdata = w_pc_plus4;
                w_pc_next = r_pc + w_imm_j;
            end
            OPC_JALR: begin
                w_legal = (w_funct3 == 3'b000); w_rf_we_dec = 1'b1; w_rf_wdata = w_pc_plus4;
                w_pc_next = (w_rs1_val + w_imm_i) & ~32'd1;
            end
            OPC_BRANCH: begin
                w_legal = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
                if (w_taken) w_pc_next = r_pc + w_imm_b;
            end
            OPC_LOAD: begin
                w_legal = (w_funct3 == F3_LW) && (w_mem_addr[1:0] == 2'b00);
                w_rf_we_dec = 1'b1; w_rf_wdata = w_load_data;
            end
            OPC_STORE: begin
                w_legal = (w_funct3 == F3_LW) && (w_mem_addr[1:0] == 2'b00);
                w_store_dec = 1'b1;
            end
            OPC_OP_IMM: begin
                w_rf_we_dec = 1'b1;
                if (w_funct3 == F3_SLL)     w_legal = (w_funct7 == F7_BASE);
                else if (w_funct3 == F3_SR) w_legal = (w_funct7 == F7_BASE) || (w_funct7 == F7_ALT);
                else                        w_legal = 1'b1;
            end
            OPC_OP: begin
                w_rf_we_dec = 1'b1;
                w_legal = (w_funct7 == F7_BASE) ||
                          ((w_funct7 == F7_ALT) && ((w_funct3 == F3_ADD) || (w_funct3 == F3_SR)));
            end
            OPC_SYSTEM: begin
                w_legal  = (w_instr == INSTR_EBREAK);
                w_ebreak = w_legal;
            end
            default: w_legal = 1'b0;
        endcase
    end

    logic w_run, w_exec;
    assign w_run   = fetch_enable_i && !r_halted;
    assign w_exec  = w_run && w_legal && !w_ebreak;
    assign w_rf_we = w_exec && w_rf_we_dec && !rst_ni;

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            r_pc         <= RESET_PC;
            r_halted     <= 1'b0;
            r_mem_flag   <= '0;
            r_mem_result <= '0;
        end else if (w_run) begin
            if (w_exec) begin
                r_pc <= w_pc_next;
                if (w_store_dec && w_flag_hit) begin
                    r_mem_flag <= w_rs2_val;
                    if (w_rs2_val != '0) r_halted <= 1'b1;
                end
                if (w_store_dec && w_result_hit) r_mem_result <= w_rs2_val;
            end else begin
                r_halted <= 1'b1;
            end
        end
    end

    // NOTE: RAM contents are deliberately left out of reset; only the write enable honours it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni && w_exec && w_store_dec && w_ram_hit) begin
            r_ram[w_ram_idx] <= w_rs2_val;
        end
    end

    assign signal     = r_halted;
    assign result     = w_x10;
    assign mem_flag   = r_mem_flag;
    assign mem_result = r_mem_result;
    assign instr_addr = r_pc;

endmodule

// File: tb/tb_zeroriscy_mini_soc.sv
// Directed bench for zeroriscy_mini_soc: small hand-assembled programs are loaded into the ROM,
// expected outputs are queued as each step is driven and compared when the DUT reaches that point.
module tb_zeroriscy_mini_soc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        signal;
    logic [31:0] result, mem_flag, mem_result, instr_addr;

    zeroriscy_mini_soc dut (
        .clk_i          (clk),
        .rst_ni         (rst),
        .fetch_enable_i (fetch_en),
        .signal         (signal),
        .result         (result),
        .mem_flag       (mem_flag),
        .mem_result     (mem_result),
        .instr_addr     (instr_addr)
    );

    always #5 clk = ~clk;

    typedef enum {O_PC, O_SIG, O_RES, O_FLAG, O_MRES} obs_e;
    typedef struct {
        string       tag;
        obs_e        which;
        logic [31:0] exp;
    } sb_t;

    sb_t         sb_q[$];
    logic [31:0] prog[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [31:0] enc_i(logic [6:0] op, logic [4:0] rd, logic [2:0] f3,
                                          logic [4:0] rs1, logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(logic [4:0] rs2, logic [4:0] rs1, logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(logic [2:0] f3, logic [4:0] rs1, logic [4:0] rs2,
                                          logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(logic [6:0] op, logic [4:0] rd, logic [19:0] imm);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] observe(obs_e w);
        case (w)
            O_PC:    return instr_addr;
            O_SIG:   return {31'b0, signal};
            O_RES:   return result;
            O_FLAG:  return mem_flag;
            default: return mem_result;
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(string tag, obs_e w, logic [31:0] v);
        sb_t e;
        e.tag = tag; e.which = w; e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, observe(e.which), e.exp);
        end
    endtask

    task automatic p(logic [31:0] w);
        prog.push_back(w);
    endtask

    // Load the queued program (rest of ROM zero) and hold reset for three edges.
    task automatic load_and_reset();
        rst      = 1'b1;
        fetch_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            dut.r_rom[i] = (i < prog.size()) ? prog[i] : 32'h0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_halt(string tag, int budget);
        for (int i = 0; i < budget && !signal; i++) @(negedge clk);
        check(tag, {31'b0, signal}, 32'd1);
    endtask

    task automatic sum_program();
        prog.delete();
        p(enc_i(7'h13, 5'd10, 3'd0, 5'd0, 12'd0));        // 00 addi a0,x0,0
        p(enc_i(7'h13, 5'd5,  3'd0, 5'd0, 12'd1));        // 04 addi t0,x0,1
        p(enc_i(7'h13, 5'd6,  3'd0, 5'd0, 12'd11));       // 08 addi t1,x0,11
        p(enc_r(7'h00, 5'd5, 5'd10, 3'd0, 5'd10));        // 0c add a0,a0,t0
        p(enc_i(7'h13, 5'd5,  3'd0, 5'd5, 12'd1));        // 10 addi t0,t0,1
        p(enc_b(3'd1, 5'd5, 5'd6, 13'h1FF8));             // 14 bne t0,t1,-8
        p(enc_u(7'h37, 5'd7, 20'h00001));                 // 18 lui t2,1
        p(enc_s(5'd10, 5'd7, 12'd4));                     // 1c sw a0,4(t2)
        p(enc_i(7'h13, 5'd8,  3'd0, 5'd0, 12'd1));        // 20 addi s0,x0,1
        p(enc_s(5'd8, 5'd7, 12'd0));                      // 24 sw s0,0(t2)
    endtask

    initial begin
        // Reset state and the sum-of-1..10 program.
        sum_program();
        load_and_reset();
        expect_out("rst_pc",   O_PC,   32'h0);
        expect_out("rst_sig",  O_SIG,  32'h0);
        expect_out("rst_flag", O_FLAG, 32'h0);
        expect_out("rst_res",  O_RES,  32'h0);
        expect_out("rst_mres", O_MRES, 32'h0);
        drain();
        rst = 1'b0;
        wait_halt("sum_halt", 200);
        expect_out("sum_mres", O_MRES, 32'd55);
        expect_out("sum_res",  O_RES,  32'd55);
        expect_out("sum_flag", O_FLAG, 32'd1);
        expect_out("sum_pc",   O_PC,   32'h28);
        drain();
        repeat (3) @(negedge clk);
        expect_out("sum_pc_sticky", O_PC, 32'h28);
        drain();

        // Freeze mid-loop for five cycles, then resume.
        load_and_reset();
        rst = 1'b0;
        repeat (7) @(negedge clk);
        fetch_en = 1'b0;
        expect_out("frz_pc",  O_PC,  32'h10);
        expect_out("frz_res", O_RES, 32'd3);
        expect_out("frz_sig", O_SIG, 32'h0);
        repeat (5) @(negedge clk);
        drain();
        fetch_en = 1'b1;
        wait_halt("frz_halt", 200);
        expect_out("frz_mres", O_MRES, 32'd55);
        expect_out("frz_end_pc", O_PC, 32'h28);
        drain();

        // x0 immutability, LUI/SRAI sign fill, signed vs unsigned compares, EBREAK.
        prog.delete();
        p(enc_i(7'h13, 5'd10, 3'd0, 5'd0, 12'd7));        // 00 addi a0,x0,7
        p(enc_i(7'h13, 5'd0,  3'd0, 5'd0, 12'd5));        // 04 addi x0,x0,5
        p(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd10));         // 08 add a0,x0,x0
        p(enc_u(7'h37, 5'd10, 20'h80000));                // 0c lui a0,0x80000
        p(enc_i(7'h13, 5'd10, 3'd5, 5'd10, 12'h404));     // 10 srai a0,a0,4
        p(enc_i(7'h13, 5'd11, 3'd0, 5'd0, 12'hFFF));      // 14 addi a1,x0,-1
        p(enc_r(7'h00, 5'd11, 5'd0, 3'd3, 5'd12));        // 18 sltu a2,x0,a1
        p(enc_r(7'h00, 5'd0, 5'd11, 3'd2, 5'd13));        // 1c slt a3,a1,x0
        p(enc_r(7'h00, 5'd12, 5'd10, 3'd0, 5'd10));       // 20 add a0,a0,a2
        p(enc_r(7'h00, 5'd13, 5'd10, 3'd0, 5'd10));       // 24 add a0,a0,a3
        p(32'h0010_0073);                                 // 28 ebreak
        load_and_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        expect_out("alu_addi", O_RES, 32'd7);
        drain();
        @(negedge clk);
        expect_out("alu_x0", O_RES, 32'd0);
        drain();
        repeat (2) @(negedge clk);
        expect_out("alu_srai", O_RES, 32'hF800_0000);
        drain();
        wait_halt("alu_halt", 50);
        expect_out("alu_cmp", O_RES,  32'hF800_0002);
        expect_out("alu_pc",  O_PC,   32'h28);
        expect_out("alu_flag", O_FLAG, 32'h0);
        drain();

        // RAM store/load, unmapped load, MMIO readback, zero vs nonzero flag store.
        prog.delete();
        p(enc_u(7'h37, 5'd5, 20'h00002));                 // 00 lui t0,2
        p(enc_u(7'h37, 5'd6, 20'h0000E));                 // 04 lui t1,0xE
        p(enc_i(7'h13, 5'd6, 3'd0, 5'd6, 12'hEAD));       // 08 addi t1,t1,-339
        p(enc_s(5'd6, 5'd5, 12'd8));                      // 0c sw t1,8(t0)
        p(enc_i(7'h03, 5'd10, 3'd2, 5'd5, 12'd8));        // 10 lw a0,8(t0)
        p(enc_i(7'h03, 5'd10, 3'd2, 5'd0, 12'h500));      // 14 lw a0,0x500(x0)
        p(enc_u(7'h37, 5'd7, 20'h00001));                 // 18 lui t2,1
        p(enc_s(5'd6, 5'd7, 12'd4));                      // 1c sw t1,4(t2)
        p(enc_i(7'h03, 5'd10, 3'd2, 5'd7, 12'd4));        // 20 lw a0,4(t2)
        p(enc_s(5'd0, 5'd7, 12'd0));                      // 24 sw x0,0(t2)
        p(enc_i(7'h03, 5'd10, 3'd2, 5'd7, 12'd0));        // 28 lw a0,0(t2)
        p(enc_s(5'd6, 5'd7, 12'd0));                      // 2c sw t1,0(t2)
        load_and_reset();
        rst = 1'b0;
        repeat (5) @(negedge clk);
        expect_out("mem_ram_lw", O_RES, 32'h0000_DEAD);
        drain();
        @(negedge clk);
        expect_out("mem_unmapped", O_RES, 32'h0);
        drain();
        repeat (3) @(negedge clk);
        expect_out("mem_mres_rd", O_RES,  32'h0000_DEAD);
        expect_out("mem_mres",    O_MRES, 32'h0000_DEAD);
        expect_out("mem_no_halt", O_SIG,  32'h0);
        drain();
        wait_halt("mem_halt", 20);
        expect_out("mem_flag_rd", O_RES,  32'h0);
        expect_out("mem_flag",    O_FLAG, 32'h0000_DEAD);
        expect_out("mem_pc",      O_PC,   32'h30);
        drain();

        // All-zero word is illegal: halt next cycle with PC held; reset clears it.
        prog.delete();
        p(enc_i(7'h13, 5'd10, 3'd0, 5'd0, 12'd1));        // 00 addi a0,x0,1
        load_and_reset();
        rst = 1'b0;
        @(negedge clk);
        expect_out("ill_pc1",  O_PC,  32'h4);
        expect_out("ill_sig1", O_SIG, 32'h0);
        drain();
        @(negedge clk);
        expect_out("ill_sig2", O_SIG, 32'h1);
        expect_out("ill_pc2",  O_PC,  32'h4);
        expect_out("ill_res",  O_RES, 32'h1);
        drain();
        repeat (2) @(negedge clk);
        expect_out("ill_pc_hold", O_PC, 32'h4);
        drain();
        rst = 1'b1;
        @(negedge clk);
        expect_out("ill_rst_sig", O_SIG, 32'h0);
        expect_out("ill_rst_pc",  O_PC,  32'h0);
        expect_out("ill_rst_res", O_RES, 32'h0);
        drain();

        // JALR clears bit 0 but a bit-1 target is misaligned and halts on its fetch.
        prog.delete();
        p(enc_i(7'h13, 5'd5, 3'd0, 5'd0, 12'd6));         // 00 addi t0,x0,6
        p(enc_i(7'h67, 5'd1, 3'd0, 5'd5, 12'd1));         // 04 jalr ra,1(t0)
        load_and_reset();
        rst = 1'b0;
        wait_halt("jalr_halt", 10);
        expect_out("jalr_pc", O_PC, 32'h6);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
